// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port SRAM macro port 0.
// The slave modport is the arbiter's view; master is the environment (requesters + macro).
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic [1:0]        rq_req_i;
    logic [1:0]        rq_we_i;
    logic [ADDR_W-1:0] rq0_addr_i;
    logic [ADDR_W-1:0] rq1_addr_i;
    logic [MASK_W-1:0] rq0_wmask_i;
    logic [MASK_W-1:0] rq1_wmask_i;
    logic [DATA_W-1:0] rq0_wdata_i;
    logic [DATA_W-1:0] rq1_wdata_i;
    logic [1:0]        rq_gnt_o;
    logic [1:0]        rq_rvalid_o;
    logic [DATA_W-1:0] rq_rdata_o;
    logic              busy_o;
    logic              sram_csb0_o;
    logic              sram_web0_o;
    logic [MASK_W-1:0] sram_wmask0_o;
    logic [ADDR_W-1:0] sram_addr0_o;
    logic [DATA_W-1:0] sram_din0_o;
    logic [DATA_W-1:0] sram_dout0_i;

    modport slave (
        input  rq_req_i, rq_we_i, rq0_addr_i, rq1_addr_i,
        input  rq0_wmask_i, rq1_wmask_i, rq0_wdata_i, rq1_wdata_i,
        input  sram_dout0_i,
        output rq_gnt_o, rq_rvalid_o, rq_rdata_o, busy_o,
        output sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o
    );

    modport master (
        output rq_req_i, rq_we_i, rq0_addr_i, rq1_addr_i,
        output rq0_wmask_i, rq1_wmask_i, rq0_wdata_i, rq1_wdata_i,
        output sram_dout0_i,
        input  rq_gnt_o, rq_rvalid_o, rq_rdata_o, busy_o,
        input  sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for SRAM macro port 0: IDLE -> ISSUE (-> RESP for reads) -> IDLE.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module sram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_port_arbiter_if.slave   bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              win_q, win_d;
    logic              take;
    logic              pick;
`ifdef SRAM_ARB_RR_EN
    logic              ptr_q, ptr_d;
`endif

    assign take = (state_q == IDLE) && (|bus.rq_req_i);

    // Winner selection and capture of its fields; fields are frozen outside IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
`ifdef SRAM_ARB_RR_EN
        ptr_d = ptr_q;
        pick  = (bus.rq_req_i == 2'b11) ? ptr_q : bus.rq_req_i[1];
`else
        pick  = ~bus.rq_req_i[0];
`endif
        we_d    = we_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        din_d   = din_q;
        win_d   = win_q;
        if (take) begin
            win_d   = pick;
            we_d    = bus.rq_we_i[pick];
            addr_d  = pick ? bus.rq1_addr_i  : bus.rq0_addr_i;
            wmask_d = pick ? bus.rq1_wmask_i : bus.rq0_wmask_i;
            din_d   = pick ? bus.rq1_wdata_i : bus.rq0_wdata_i;
`ifdef SRAM_ARB_RR_EN
            ptr_d   = ~pick;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|bus.rq_req_i) state_d = ISSUE;
            ISSUE:   state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wmask_q <= '0;
            din_q   <= '0;
            win_q   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            din_q   <= din_d;
            win_q   <= win_d;
`ifdef SRAM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Strobes decode straight from the state flop so reset kills them without waiting for an edge.
    always_comb begin
        bus.sram_csb0_o   = 1'b1;
        bus.sram_web0_o   = 1'b1;
        bus.sram_wmask0_o = wmask_q;
        bus.sram_addr0_o  = addr_q;
        bus.sram_din0_o   = din_q;
        bus.rq_gnt_o      = 2'b00;
        bus.rq_rvalid_o   = 2'b00;
        bus.rq_rdata_o    = '0;
        bus.busy_o        = (state_q != IDLE);
        unique case (state_q)
            ISSUE: begin
                bus.sram_csb0_o     = 1'b0;
                bus.sram_web0_o     = ~we_q;
                bus.rq_gnt_o[win_q] = 1'b1;
            end
            RESP: begin
                bus.rq_rvalid_o[win_q] = 1'b1;
                bus.rq_rdata_o         = bus.sram_dout0_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a byte-masked behavioural SRAM model.
// Works with or without SRAM_ARB_RR_EN; tie-break expectations follow the macro.
module tb_sram_port_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Macro model: one access per edge with csb low, read data appears after that edge.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] dout;
    initial begin
        dout = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h1000_0000 | i;
    end
    always @(posedge clk) begin
        if (!bus.sram_csb0_o) begin
            if (!bus.sram_web0_o) begin
                for (int b = 0; b < DATA_W / 8; b++)
                    if (bus.sram_wmask0_o[b]) mem[bus.sram_addr0_o][8*b +: 8] <= bus.sram_din0_o[8*b +: 8];
            end else begin
                dout <= mem[bus.sram_addr0_o];
            end
        end
    end
    assign bus.sram_dout0_i = dout;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [7:0] addr,
                           input logic [3:0] wmask, input logic [31:0] wdata);
        bus.rq_req_i[r] = 1'b1;
        bus.rq_we_i[r]  = we;
        if (r == 0) begin
            bus.rq0_addr_i = addr; bus.rq0_wmask_i = wmask; bus.rq0_wdata_i = wdata;
        end else begin
            bus.rq1_addr_i = addr; bus.rq1_wmask_i = wmask; bus.rq1_wdata_i = wdata;
        end
    endtask

    initial begin
        logic [1:0] exp_gnt;

        rst_n           = 1'b0;
        bus.rq_req_i    = 2'b00;
        bus.rq_we_i     = 2'b00;
        bus.rq0_addr_i  = '0; bus.rq1_addr_i  = '0;
        bus.rq0_wmask_i = '0; bus.rq1_wmask_i = '0;
        bus.rq0_wdata_i = '0; bus.rq1_wdata_i = '0;

        // Reset values
        #12;
        check("rst_csb",    bus.sram_csb0_o,   1);
        check("rst_web",    bus.sram_web0_o,   1);
        check("rst_wmask",  bus.sram_wmask0_o, 0);
        check("rst_addr",   bus.sram_addr0_o,  0);
        check("rst_din",    bus.sram_din0_o,   0);
        check("rst_gnt",    bus.rq_gnt_o,      0);
        check("rst_rvalid", bus.rq_rvalid_o,   0);
        check("rst_busy",   bus.busy_o,        0);
        check("rst_rdata",  bus.rq_rdata_o,    0);
        #10 rst_n = 1'b1;
        tick();
        check("post_rst_idle", bus.busy_o, 0);

        // r0 full write 0xDEADBEEF to 0x05
        set_req(0, 1'b1, 8'h05, 4'hF, 32'hDEAD_BEEF);
        tick();
        check("wr_csb",   bus.sram_csb0_o,   0);
        check("wr_web",   bus.sram_web0_o,   0);
        check("wr_addr",  bus.sram_addr0_o,  8'h05);
        check("wr_din",   bus.sram_din0_o,   32'hDEAD_BEEF);
        check("wr_wmask", bus.sram_wmask0_o, 4'hF);
        check("wr_gnt",   bus.rq_gnt_o,      2'b01);
        check("wr_busy",  bus.busy_o,        1);
        bus.rq_req_i = 2'b00;
        tick();
        check("wr_done_busy", bus.busy_o,      0);
        check("wr_done_csb",  bus.sram_csb0_o, 1);
        check("wr_done_gnt",  bus.rq_gnt_o,    0);

        // r1 read of 0x05
        set_req(1, 1'b0, 8'h05, 4'h0, 32'h0);
        tick();
        check("rd_gnt",  bus.rq_gnt_o,    2'b10);
        check("rd_csb",  bus.sram_csb0_o, 0);
        check("rd_web",  bus.sram_web0_o, 1);
        check("rd_addr", bus.sram_addr0_o, 8'h05);
        bus.rq_req_i = 2'b00;
        tick();
        check("rd_rvalid", bus.rq_rvalid_o, 2'b10);
        check("rd_rdata",  bus.rq_rdata_o,  32'hDEAD_BEEF);
        check("rd_resp_csb", bus.sram_csb0_o, 1);
        check("rd_resp_web", bus.sram_web0_o, 1);
        check("rd_resp_gnt", bus.rq_gnt_o,    0);
        tick();
        check("rd_done_rvalid", bus.rq_rvalid_o, 0);
        check("rd_done_rdata",  bus.rq_rdata_o,  0);
        check("rd_done_busy",   bus.busy_o,      0);

        // Both requesters hold reads for 8 accesses
        set_req(0, 1'b0, 8'h05, 4'h0, 32'h0);
        set_req(1, 1'b0, 8'h05, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_RR_EN
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b01;
`endif
            tick();
            check($sformatf("tie_gnt_%0d", i), bus.rq_gnt_o, exp_gnt);
            tick();
            check($sformatf("tie_rvalid_%0d", i), bus.rq_rvalid_o, exp_gnt);
            check($sformatf("tie_rdata_%0d", i), bus.rq_rdata_o, 32'hDEAD_BEEF);
            tick();
        end
        bus.rq_req_i = 2'b00;

        // Reset in the ISSUE cycle of a read aborts it
        tick();
        set_req(0, 1'b0, 8'h05, 4'h0, 32'h0);
        tick();
        check("abort_issue_csb", bus.sram_csb0_o, 0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_csb",  bus.sram_csb0_o, 1);
        check("abort_gnt",  bus.rq_gnt_o,    0);
        check("abort_busy", bus.busy_o,      0);
        bus.rq_req_i = 2'b00;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_no_rvalid_%0d", i), bus.rq_rvalid_o, 0);
        end

        // Address change after sampling does not affect the access in flight
        set_req(0, 1'b0, 8'h10, 4'h0, 32'h0);
        tick();
        check("hold_addr_issue", bus.sram_addr0_o, 8'h10);
        bus.rq0_addr_i = 8'h20;
        bus.rq_req_i   = 2'b00;
        tick();
        check("hold_addr_resp", bus.sram_addr0_o, 8'h10);
        check("hold_rdata",     bus.rq_rdata_o,   32'h1000_0010);
        check("hold_rvalid",    bus.rq_rvalid_o,  2'b01);
        tick();

        // Partial byte-mask write, then all-zero mask write, then read back
        set_req(0, 1'b1, 8'h05, 4'h3, 32'hAAAA_5555);
        tick();
        check("pw_wmask", bus.sram_wmask0_o, 4'h3);
        bus.rq_req_i = 2'b00;
        tick();
        set_req(0, 1'b1, 8'h05, 4'h0, 32'h1234_5678);
        tick();
        check("zw_csb",   bus.sram_csb0_o,   0);
        check("zw_web",   bus.sram_web0_o,   0);
        check("zw_gnt",   bus.rq_gnt_o,      2'b01);
        check("zw_wmask", bus.sram_wmask0_o, 4'h0);
        bus.rq_req_i = 2'b00;
        tick();
        check("zw_done_csb", bus.sram_csb0_o, 1);
        set_req(1, 1'b0, 8'h05, 4'h0, 32'h0);
        tick();
        check("rb_gnt", bus.rq_gnt_o, 2'b10);
        bus.rq_req_i = 2'b00;
        tick();
        check("rb_rdata", bus.rq_rdata_o, 32'hDEAD_5555);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the word address width of the macro port.
REQ-002 The module SHALL have parameter DATA_W, default 32, giving the data width; the byte-mask width is DATA_W/8.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Ports rq_req_i, rq_we_i, input, 2 each: per requester r (0/1), the access request and the write flag (1=write).
REQ-006 Ports rq0_addr_i and rq1_addr_i, input, ADDR_W each: the word address for each requester.
REQ-007 Ports rq0_wmask_i and rq1_wmask_i, input, DATA_W/8 each, and rq0_wdata_i and rq1_wdata_i, input, DATA_W each: byte mask and write data for each requester.
REQ-008 Port rq_gnt_o, output, 2: a one-cycle grant pulse per requester.
REQ-009 Port rq_rvalid_o, output, 2: a one-cycle read-data-valid pulse per requester.
REQ-010 Port rq_rdata_o, output, DATA_W: read data, shared by both requesters.
REQ-011 Port busy_o, output, 1: high whenever the FSM is not in IDLE.
REQ-012 Ports sram_csb0_o and sram_web0_o, output, 1 each: the macro port-0 chip select and write enable, both active-low.
REQ-013 Ports sram_wmask0_o (DATA_W/8), sram_addr0_o (ADDR_W) and sram_din0_o (DATA_W), output: macro port-0 byte mask, address and write data.
REQ-014 Port sram_dout0_i, input, DATA_W: macro port-0 read data, valid in the cycle after the access edge.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-016 In IDLE with any rq_req_i bit high, the block SHALL pick one winner, register the winner's we/addr/wmask/wdata onto the sram_* outputs and move to ISSUE.
REQ-017 In IDLE with no request, the FSM SHALL stay in IDLE with sram_csb0_o=1.
REQ-018 In ISSUE, sram_csb0_o SHALL be 0 for exactly one cycle; sram_web0_o SHALL be 0 for a write and 1 for a read; rq_gnt_o[winner] SHALL be 1 in the same cycle.
REQ-019 After ISSUE, the FSM SHALL go to RESP for a read and to IDLE for a write.
REQ-020 In RESP, rq_rvalid_o[winner] SHALL be 1 and rq_rdata_o SHALL equal sram_dout0_i; the FSM SHALL then go to IDLE.
REQ-021 Timing: a request seen in IDLE at cycle N SHALL be granted at N+1; read data SHALL be valid at N+2.
REQ-022 Peak throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-023 A requester SHALL hold req and its fields stable until its grant; fields are sampled only in IDLE, so a change after sampling SHALL NOT affect the access in flight.
REQ-024 A requester that keeps req high after its grant SHALL be treated as a new request at the next IDLE.
REQ-025 Outside ISSUE, sram_csb0_o SHALL be 1 and sram_web0_o SHALL be 1.
REQ-026 A write with an all-zero wmask SHALL be issued as a normal write.
REQ-027 At most one rq_gnt_o bit and at most one rq_rvalid_o bit SHALL be high in any cycle.
REQ-028 rq_rdata_o SHALL be 0 outside RESP.

Reset
REQ-029 While rst_n=0, asynchronously: FSM=IDLE, sram_csb0_o=1, sram_web0_o=1, sram_wmask0_o=0, sram_addr0_o=0, sram_din0_o=0, rq_gnt_o=0, rq_rvalid_o=0, busy_o=0, priority pointer=requester 0.
REQ-030 Reset asserted during ISSUE or RESP SHALL abort the access with no grant or rvalid pulse delivered afterwards.
REQ-031 On the first edge after reset release, the block SHALL behave as IDLE.

Configuration
REQ-032 The macro SRAM_ARB_RR_EN SHALL select the arbitration scheme.
REQ-033 With SRAM_ARB_RR_EN defined, simultaneous requests SHALL be served round-robin: the pointer moves to the other requester on each grant, and the requester not granted last wins a tie.
REQ-034 Without SRAM_ARB_RR_EN, requester 0 SHALL always win a tie (fixed priority), and no pointer register SHALL exist.

Verification
REQ-035 Scenario: reset, then r0 write addr=0x05 wmask=0xF data=0xDEADBEEF -> at N+1, csb0=0, web0=0, addr0=0x05, din0=0xDEADBEEF, gnt=2'b01; FSM returns to IDLE at N+2.
REQ-036 Scenario: r1 read addr=0x05 after the write -> gnt=2'b10 at N+1; rvalid=2'b10 and rdata=0xDEADBEEF at N+2.
REQ-037 Scenario: both requesters hold read requests for 8 accesses with RR enabled -> grant order 0,1,0,1,...; with RR disabled -> r0 granted every time while it keeps req high.
REQ-038 Scenario: rst_n pulled low in the ISSUE cycle of a read -> csb0=1 immediately and no rvalid pulse follows.
REQ-039 Scenario: r0 changes addr from 0x10 to 0x20 in the ISSUE cycle -> sram_addr0_o stays 0x10.
REQ-040 Scenario: r0 write with wmask=0x0 -> csb0=0 and web0=0 for one cycle, gnt=2'b01, and the memory contents are unchanged.
